// File: rtl/i8bit_div.sv
// Sequential restoring divider producing one quotient bit per clock, with valid/ready on both sides.
// Define I8BIT_DIV_BYPASS_EN to finish divide-by-zero and divisor>dividend in a single cycle.
module i8bit_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div_by_zero_q, div_by_zero_d;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] r_step;

   // The partial remainder never reaches the divisor, so its top bit lives only in the trial value.
   always_comb begin
      trial  = {r_q, q_q[WIDTH-1]};
      diff   = trial - {1'b0, d_q};
      fits   = ~diff[WIDTH];
      q_step = {q_q[WIDTH-2:0], fits};
      r_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   always_comb begin
      state_d       = state_q;
      q_d           = q_q;
      d_d           = d_q;
      r_d           = r_q;
      cnt_d         = cnt_q;
      dbz_d         = dbz_q;
      quot_d        = quot_q;
      rem_d         = rem_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_d     = dividend;
               d_d     = divisor;
               r_d     = '0;
               cnt_d   = CNT_W'(WIDTH - 1);
               dbz_d   = (divisor == '0);
               state_d = BUSY;
`ifdef I8BIT_DIV_BYPASS_EN
               if ((divisor == '0) || (divisor > dividend)) begin
                  state_d       = DONE;
                  quot_d        = (divisor == '0) ? '1 : '0;
                  rem_d         = dividend;
                  div_by_zero_d = (divisor == '0);
               end
`endif
            end
         end
         BUSY: begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d       = DONE;
               quot_d        = q_step;
               rem_d         = r_step;
               div_by_zero_d = dbz_q;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         q_q           <= '0;
         d_q           <= '0;
         r_q           <= '0;
         cnt_q         <= '0;
         dbz_q         <= 1'b0;
         quot_q        <= '0;
         rem_q         <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         q_q           <= q_d;
         d_q           <= d_d;
         r_q           <= r_d;
         cnt_q         <= cnt_d;
         dbz_q         <= dbz_d;
         quot_q        <= quot_d;
         rem_q         <= rem_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quot        = quot_q;
   assign rem         = rem_q;
   assign div_by_zero = div_by_zero_q;

endmodule
